mem_read_arbiter: RTL and testbench
===================================

// Module: mem_read_arbiter
// PURPOSE
//  Shares one line-wide backing-memory read port between two cache requesters (req0 = instruction
//  cache, req1 = data cache). Each requester port mirrors a cache's memory-side interface.
//  Arbitration is round-robin; the grant is held until the memory returns the line.
//  Sits between the caches' mem_* ports and the memory model/bus.
// PARAMETERS
//  LineSize   128  bits per cache line (memory data width)
//  AddrWidth  32   address width
// PORTS
//  clk_i             in   1          clock, all state on rising edge
//  rst_i             in   1          synchronous reset, active-high
//  req0_read_en_i    in   1          requester 0 wants a line; held high until its valid
//  req0_addr_i       in   AddrWidth  requester 0 line address (offset bits zero)
//  req0_read_valid_o out  1          1-cycle pulse: line for requester 0 on req0_read_data_o
//  req0_read_data_o  out  LineSize   line data to requester 0
//  req1_*            same set as req0_* for requester 1
//  mem_addr_o        out  AddrWidth  address to memory (registered)
//  mem_read_en_o     out  1          memory read request (registered)
//  mem_read_valid_i  in   1          memory line valid, 1-cycle pulse
//  mem_read_data_i   in   LineSize   memory line data
//  grant_o           out  2          one-hot current owner, 2'b00 when none
// BEHAVIOUR
//  - Reset (rst_i=1 at a clock edge): state IDLE, all outputs 0, aborted=0, last_grant=1 (req0 wins
//    the first tie). Reset mid-transaction drops it; a later mem_read_valid_i is ignored.
//  - States: IDLE, BUSY, DONE.
//  - IDLE: if any reqX_read_en_i=1, choose owner: only one requesting -> it; both -> the one !=
//    last_grant. Latch owner's addr into mem_addr_o, set mem_read_en_o=1, grant_o, -> BUSY.
//    Latency request -> mem_read_en_o high = 1 cycle.
//  - BUSY: mem_read_en_o, mem_addr_o, grant_o held stable. If owner's read_en_i is 0 in any BUSY
//    cycle, set aborted=1 (memory read cannot be cancelled). On mem_read_valid_i=1:
//    owner_read_valid_o = !aborted (combinational, same cycle), owner_read_data_o =
//    mem_read_data_i; last_grant<=owner; mem_read_en_o<=0, grant_o<=0, aborted<=0; -> DONE.
//  - DONE: one dead cycle, no grant, so the requester can drop its read_en_i after its valid
//    and is not re-granted for the same line; -> IDLE.
//  - Non-owner reqX_read_valid_o always 0; reqX_read_data_o = 0 when its valid is 0.
//  - mem_read_valid_i outside BUSY is ignored (no valid forwarded, no state change).
//  - Requests arriving in BUSY/DONE wait; requester must hold read_en_i and addr stable.
//  - Fairness: with both requesters continuously active, grants alternate 0,1,0,1...; worst-case
//    wait = one foreign transaction + 2 cycles.
//  - Address changes on the owner's addr input during BUSY have no effect (latched copy used).
// TESTING
//  1. Reset, req0_en=1 addr=0x100 -> next cycle mem_read_en_o=1, mem_addr_o=0x100, grant_o=01;
//     mem valid after 3 cycles with data D -> req0_read_valid_o=1, req0_read_data_o=D same cycle.
//  2. Both requesters high from reset (0x200/0x300), memory latency 2 -> mem_addr_o sequence
//     0x200,0x300,0x200; each valid routed only to its owner; 2 dead cycles between transactions.
//  3. req1 granted, req1_en dropped in BUSY before valid -> mem_read_en_o held until valid,
//     req1_read_valid_o stays 0, state returns to IDLE via DONE.
//  4. Spurious mem_read_valid_i=1 in IDLE with no requests -> no valid outputs, grant_o=00.
//  5. rst_i=1 during BUSY, then memory valid arrives -> ignored, all outputs 0, next tie goes req0.
//  6. req0 drops en in DONE after valid, req1 requesting -> req1 granted at next IDLE cycle.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
//   Two caches share one line-wide memory read port. Requester 0 is the
//   instruction cache and requester 1 is the data cache. Arbitration is
//   round-robin. The winner keeps the grant until memory returns its line.
//   A single dead cycle (DONE) follows each line, so the requester can drop
//   its request without being granted the same line a second time.
// Ports
//   clk_i, rst_i                     clock, synchronous active-high reset
//   reqN_read_en_i / reqN_addr_i     line request and line address, N = 0, 1
//   reqN_read_valid_o / _data_o      1-cycle line delivery to requester N
//   mem_addr_o / mem_read_en_o       registered request to memory
//   mem_read_valid_i / _data_i       line returned by memory
//   grant_o                          one-hot owner, 2'b00 when no owner

// Per-requester return path. The line data is zero whenever the valid is low.
module mem_read_arbiter_port #(
  parameter int LineSize = 128
) (
  input  logic                sel_i,
  input  logic [LineSize-1:0] mem_data_i,
  output logic                valid_o,
  output logic [LineSize-1:0] data_o
);
  assign valid_o = sel_i;
  assign data_o  = sel_i ? mem_data_i : '0;
endmodule

module mem_read_arbiter #(
  parameter int LineSize  = 128,
  parameter int AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req0_read_en_i,
  input  logic [AddrWidth-1:0] req0_addr_i,
  output logic                 req0_read_valid_o,
  output logic [LineSize-1:0]  req0_read_data_o,
  input  logic                 req1_read_en_i,
  input  logic [AddrWidth-1:0] req1_addr_i,
  output logic                 req1_read_valid_o,
  output logic [LineSize-1:0]  req1_read_data_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_read_en_o,
  input  logic                 mem_read_valid_i,
  input  logic [LineSize-1:0]  mem_read_data_i,
  output logic [1:0]           grant_o
);
  localparam int NumReq = 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_grant_q, last_grant_d;
  logic                   aborted_q, aborted_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   rd_en_q, rd_en_d;
  logic [1:0]             grant_q, grant_d;

  logic [NumReq-1:0]                req_en;
  logic [NumReq-1:0][AddrWidth-1:0] req_addr;
  logic [NumReq-1:0]                fwd;
  logic [NumReq-1:0]                rd_valid;
  logic [NumReq-1:0][LineSize-1:0]  rd_data;

  assign req_en   = {req1_read_en_i, req0_read_en_i};
  assign req_addr = {req1_addr_i, req0_addr_i};

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    aborted_d    = aborted_q;
    addr_d       = addr_q;
    rd_en_d      = rd_en_q;
    grant_d      = grant_q;
    case (state_q)
      IDLE: begin
        if (|req_en) begin
          // On a tie, the requester that was not served last wins.
          // Otherwise the only active requester wins.
          owner_d = (&req_en) ? ~last_grant_q : req_en[1];
          addr_d  = req_addr[owner_d];
          rd_en_d = 1'b1;
          grant_d = owner_d ? 2'b10 : 2'b01;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A memory read cannot be cancelled. If the owner walks away, the
        // read still runs to completion and the returned line is discarded.
        if (!req_en[owner_q]) aborted_d = 1'b1;
        if (mem_read_valid_i) begin
          last_grant_d = owner_q;
          rd_en_d      = 1'b0;
          grant_d      = 2'b00;
          aborted_d    = 1'b0;
          state_d      = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      aborted_q    <= 1'b0;
      addr_q       <= '0;
      rd_en_q      <= 1'b0;
      grant_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      aborted_q    <= aborted_d;
      addr_q       <= addr_d;
      rd_en_q      <= rd_en_d;
      grant_q      <= grant_d;
    end
  end

  // The returned line goes straight to the owner in the same cycle it
  // arrives. grant_q is one-hot on the owner for the whole BUSY period.
  assign fwd = (state_q == BUSY && mem_read_valid_i && !aborted_q) ? grant_q : '0;

  for (genvar g = 0; g < NumReq; g++) begin : g_port
    mem_read_arbiter_port #(.LineSize(LineSize)) u_port (
      .sel_i      (fwd[g]),
      .mem_data_i (mem_read_data_i),
      .valid_o    (rd_valid[g]),
      .data_o     (rd_data[g])
    );
  end

  assign req0_read_valid_o = rd_valid[0];
  assign req0_read_data_o  = rd_data[0];
  assign req1_read_valid_o = rd_valid[1];
  assign req1_read_data_o  = rd_data[1];
  assign mem_addr_o        = addr_q;
  assign mem_read_en_o     = rd_en_q;
  assign grant_o           = grant_q;
endmodule

// File: tb/tb_mem_read_arbiter.sv
module tb_mem_read_arbiter;
  localparam int LS = 128;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req0_read_en_i, req1_read_en_i;
  logic [AW-1:0] req0_addr_i, req1_addr_i;
  logic          req0_read_valid_o, req1_read_valid_o;
  logic [LS-1:0] req0_read_data_o, req1_read_data_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_read_en_o;
  logic          mem_read_valid_i;
  logic [LS-1:0] mem_read_data_i;
  logic [1:0]    grant_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [LS-1:0] d1 = 128'hDEADBEEF_00112233_44556677_8899AABB;
  logic [LS-1:0] d2 = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;
  logic [LS-1:0] d3 = 128'hCAFEBABE_CAFEBABE_12345678_9ABCDEF0;
  logic [LS-1:0] d4 = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;
  logic [LS-1:0] d5 = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;

  always #5 clk = ~clk;

  mem_read_arbiter #(.LineSize(LS), .AddrWidth(AW)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .req0_read_en_i    (req0_read_en_i),
    .req0_addr_i       (req0_addr_i),
    .req0_read_valid_o (req0_read_valid_o),
    .req0_read_data_o  (req0_read_data_o),
    .req1_read_en_i    (req1_read_en_i),
    .req1_addr_i       (req1_addr_i),
    .req1_read_valid_o (req1_read_valid_o),
    .req1_read_data_o  (req1_read_data_o),
    .mem_addr_o        (mem_addr_o),
    .mem_read_en_o     (mem_read_en_o),
    .mem_read_valid_i  (mem_read_valid_i),
    .mem_read_data_i   (mem_read_data_i),
    .grant_o           (grant_o)
  );

  task automatic chk(input string tag, input logic [LS-1:0] obs, input logic [LS-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [LS-1:0] dt;
    logic [AW-1:0] exp_addr;
    logic          exp_own;

    rst_i = 1'b1;
    req0_read_en_i = 1'b0; req0_addr_i = '0;
    req1_read_en_i = 1'b0; req1_addr_i = '0;
    mem_read_valid_i = 1'b0; mem_read_data_i = '0;
    tick(); tick();

    // Reset state
    chk("rst_mem_en", mem_read_en_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_v0", req0_read_valid_o, 0);
    chk("rst_v1", req1_read_valid_o, 0);
    chk("rst_d0", req0_read_data_o, 0);
    rst_i = 1'b0;

    // Single request from req0, memory returns the line in the 3rd BUSY cycle
    req0_read_en_i = 1'b1; req0_addr_i = 32'h100;
    tick();
    chk("t1_en", mem_read_en_o, 1);
    chk("t1_addr", mem_addr_o, 32'h100);
    chk("t1_grant", grant_o, 2'b01);
    req0_addr_i = 32'h180;
    tick();
    chk("t1_addr_hold", mem_addr_o, 32'h100);
    chk("t1_en_hold", mem_read_en_o, 1);
    tick();
    mem_read_valid_i = 1'b1; mem_read_data_i = d1; #1;
    chk("t1_v0", req0_read_valid_o, 1);
    chk("t1_d0", req0_read_data_o, d1);
    chk("t1_v1", req1_read_valid_o, 0);
    chk("t1_d1", req1_read_data_o, 0);
    tick();
    mem_read_valid_i = 1'b0; mem_read_data_i = '0;
    chk("t1_done_en", mem_read_en_o, 0);
    chk("t1_done_grant", grant_o, 0);
    req0_read_en_i = 1'b0; req0_addr_i = '0;
    tick();
    chk("t1_idle_grant", grant_o, 0);
    chk("t1_idle_en", mem_read_en_o, 0);

    // Spurious memory valid while IDLE
    mem_read_valid_i = 1'b1; mem_read_data_i = d2; #1;
    chk("t4_v0", req0_read_valid_o, 0);
    chk("t4_v1", req1_read_valid_o, 0);
    chk("t4_d0", req0_read_data_o, 0);
    chk("t4_d1", req1_read_data_o, 0);
    tick();
    mem_read_valid_i = 1'b0; mem_read_data_i = '0;
    chk("t4_grant", grant_o, 0);
    chk("t4_en", mem_read_en_o, 0);

    // Reset in the middle of BUSY. The late memory valid must be ignored, and
    // the next tie must go to req0 because last_grant is reset to 1.
    req0_read_en_i = 1'b1; req0_addr_i = 32'h400;
    tick();
    chk("t5_grant", grant_o, 2'b01);
    chk("t5_addr", mem_addr_o, 32'h400);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    mem_read_valid_i = 1'b1; mem_read_data_i = d3;
    req0_addr_i = 32'h600; req1_read_en_i = 1'b1; req1_addr_i = 32'h700; #1;
    chk("t5_en", mem_read_en_o, 0);
    chk("t5_addr0", mem_addr_o, 0);
    chk("t5_grant0", grant_o, 0);
    chk("t5_v0", req0_read_valid_o, 0);
    chk("t5_d0", req0_read_data_o, 0);
    chk("t5_v1", req1_read_valid_o, 0);
    tick();
    mem_read_valid_i = 1'b0; mem_read_data_i = '0;
    chk("t5_tie_grant", grant_o, 2'b01);
    chk("t5_tie_addr", mem_addr_o, 32'h600);
    chk("t5_tie_en", mem_read_en_o, 1);
    req0_read_en_i = 1'b0; req1_read_en_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;

    // req1 is granted and then drops its request during BUSY
    req1_read_en_i = 1'b1; req1_addr_i = 32'h300;
    tick();
    chk("t3_grant", grant_o, 2'b10);
    chk("t3_addr", mem_addr_o, 32'h300);
    req1_read_en_i = 1'b0;
    tick();
    chk("t3_en_hold", mem_read_en_o, 1);
    chk("t3_grant_hold", grant_o, 2'b10);
    mem_read_valid_i = 1'b1; mem_read_data_i = d4; #1;
    chk("t3_v1", req1_read_valid_o, 0);
    chk("t3_d1", req1_read_data_o, 0);
    chk("t3_v0", req0_read_valid_o, 0);
    tick();
    mem_read_valid_i = 1'b0; mem_read_data_i = '0;
    chk("t3_done_en", mem_read_en_o, 0);
    chk("t3_done_grant", grant_o, 0);
    tick();
    chk("t3_idle_en", mem_read_en_o, 0);
    req0_read_en_i = 1'b1; req0_addr_i = 32'h100;
    tick();
    chk("t3_next_grant", grant_o, 2'b01);
    req0_read_en_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;

    // Both requesters held high with a memory latency of 2. Grants must
    // alternate. In the last DONE cycle req0 drops its request, so req1 is
    // granted in the following IDLE cycle.
    req0_read_en_i = 1'b1; req0_addr_i = 32'h200;
    req1_read_en_i = 1'b1; req1_addr_i = 32'h300;
    for (int t = 0; t < 3; t++) begin
      exp_own  = (t == 1);
      exp_addr = exp_own ? 32'h300 : 32'h200;
      dt       = d5 ^ LS'(t);
      tick();
      chk($sformatf("t2_en_%0d", t), mem_read_en_o, 1);
      chk($sformatf("t2_addr_%0d", t), mem_addr_o, exp_addr);
      chk($sformatf("t2_grant_%0d", t), grant_o, exp_own ? 2'b10 : 2'b01);
      tick();
      mem_read_valid_i = 1'b1; mem_read_data_i = dt; #1;
      chk($sformatf("t2_vld_%0d", t), {req1_read_valid_o, req0_read_valid_o},
          exp_own ? 2'b10 : 2'b01);
      chk($sformatf("t2_own_data_%0d", t), exp_own ? req1_read_data_o : req0_read_data_o, dt);
      chk($sformatf("t2_oth_data_%0d", t), exp_own ? req0_read_data_o : req1_read_data_o, 0);
      tick();
      mem_read_valid_i = 1'b0; mem_read_data_i = '0;
      chk($sformatf("t2_dead1_en_%0d", t), mem_read_en_o, 0);
      chk($sformatf("t2_dead1_grant_%0d", t), grant_o, 0);
      if (t == 2) req0_read_en_i = 1'b0;
      tick();
      chk($sformatf("t2_dead2_en_%0d", t), mem_read_en_o, 0);
      chk($sformatf("t2_dead2_grant_%0d", t), grant_o, 0);
    end
    tick();
    chk("t6_grant", grant_o, 2'b10);
    chk("t6_addr", mem_addr_o, 32'h300);
    chk("t6_en", mem_read_en_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
